// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order types: ROB sizing, decode/CDB/commit bus structs and ROB entry layout.
package rv32i_types;

  localparam int ROB_ID_SIZE       = 3;
  localparam int ROB_PTR_W         = ROB_ID_SIZE + 1;
  localparam int SS_DISPATCH_WIDTH = 2;
  localparam int COMMIT_FACTOR     = 2;

  typedef logic [ROB_ID_SIZE-1:0] rob_id_t;

  typedef struct packed {
    logic       ready;
    logic [4:0] rd_addr;
  } decode_rob_bus_t;

  typedef struct packed {
    logic        valid;
    rob_id_t     rob_id;
    logic [31:0] data;
    logic        mispredict;
    logic [31:0] target;
  } cdb_bus_t;

  typedef struct packed {
    logic        ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    rob_id_t     rob_id;
  } rob_reg_data_bus_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] data;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

  // Same slot index but opposite lap: the buffer holds DEPTH entries.
  function automatic logic ptr_full(input logic [ROB_PTR_W-1:0] head,
                                    input logic [ROB_PTR_W-1:0] tail);
    return (head[ROB_ID_SIZE-1:0] == tail[ROB_ID_SIZE-1:0]) &&
           (head[ROB_ID_SIZE] != tail[ROB_ID_SIZE]);
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointers with wrap bit, occupancy and allocation-credit logic for the reorder buffer.
module rob_ptr_ctrl
  import rv32i_types::*;
#(
  parameter int DEPTH      = 2**ROB_ID_SIZE,
  parameter int DISPATCH_W = SS_DISPATCH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [ROB_PTR_W-1:0]   alloc_cnt_i,
  input  logic [ROB_PTR_W-1:0]   commit_cnt_i,
  output logic [ROB_ID_SIZE-1:0] head_idx_o,
  output logic [ROB_ID_SIZE-1:0] tail_idx_o,
  output logic                   alloc_ok_o,
  output logic                   empty_o
);

  logic [ROB_PTR_W-1:0] head_q, head_d;
  logic [ROB_PTR_W-1:0] tail_q, tail_d;
  logic [ROB_PTR_W-1:0] occ_s;

  always_comb begin
    head_d = head_q + commit_cnt_i;
    tail_d = tail_q + alloc_cnt_i;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Credit is judged on pre-edge occupancy, so slots retiring this cycle are not reused yet.
  always_comb begin
    if (ptr_full(head_q, tail_q)) begin
      occ_s = ROB_PTR_W'(DEPTH);
    end else begin
      occ_s = {1'b0, tail_q[ROB_ID_SIZE-1:0] - head_q[ROB_ID_SIZE-1:0]};
    end
  end

  assign alloc_ok_o = (ROB_PTR_W'(DEPTH) - occ_s) >= ROB_PTR_W'(DISPATCH_W);
  assign empty_o    = (head_q == tail_q);
  assign head_idx_o = head_q[ROB_ID_SIZE-1:0];
  assign tail_idx_o = tail_q[ROB_ID_SIZE-1:0];

endmodule

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: allocation, CDB completion, commit select and mispredict flush.
// Define ROB_DUAL_COMMIT_EN to retire up to COMMIT_W entries per cycle; otherwise only port 0 commits.
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH      = 2**ROB_ID_SIZE,
  parameter int DISPATCH_W = SS_DISPATCH_WIDTH,
  parameter int COMMIT_W   = COMMIT_FACTOR,
  parameter int CDB_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  decode_rob_bus_t        decode_rob_bus [DISPATCH_W],
  output logic                   alloc_ok,
  output logic [ROB_ID_SIZE-1:0] rob_head_ptr,
  input  cdb_bus_t               cdb_bus [CDB_W],
  output rob_reg_data_bus_t      data_wb_bus [COMMIT_W],
  output logic                   branch_mispredict,
  output logic [31:0]            redirect_pc,
  output logic                   rob_empty
);

`ifdef ROB_DUAL_COMMIT_EN
  localparam int ACTIVE_COMMIT = COMMIT_W;
`else
  localparam int ACTIVE_COMMIT = 1;
`endif

  rob_entry_t             rob_q [DEPTH];
  rob_entry_t             rob_d [DEPTH];
  logic [ROB_ID_SIZE-1:0] head_idx_s, tail_idx_s;
  logic                   alloc_ok_s, empty_s, flush_s, stop_s;
  logic [ROB_PTR_W-1:0]   alloc_cnt_s, commit_cnt_s;
  logic [DISPATCH_W-1:0]  alloc_fire_s;
  rob_id_t                alloc_idx_s  [DISPATCH_W];
  rob_id_t                commit_idx_s [ACTIVE_COMMIT];
  logic [ACTIVE_COMMIT-1:0] commit_s;
  logic [31:0]            redirect_s;

  rob_ptr_ctrl #(
    .DEPTH      (DEPTH),
    .DISPATCH_W (DISPATCH_W)
  ) u_ptr (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_s),
    .alloc_cnt_i  (alloc_cnt_s),
    .commit_cnt_i (commit_cnt_s),
    .head_idx_o   (head_idx_s),
    .tail_idx_o   (tail_idx_s),
    .alloc_ok_o   (alloc_ok_s),
    .empty_o      (empty_s)
  );

  // Requests are contiguous from port 0, so port i lands at tail+i.
  always_comb begin
    alloc_cnt_s  = '0;
    alloc_fire_s = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      alloc_idx_s[i]  = tail_idx_s + ROB_ID_SIZE'(i);
      alloc_fire_s[i] = alloc_ok_s & decode_rob_bus[i].ready;
      if (alloc_fire_s[i]) begin
        alloc_cnt_s = alloc_cnt_s + ROB_PTR_W'(1);
      end
    end
  end

  // Retire a prefix of done entries from head; a mispredicting entry ends the prefix.
  always_comb begin
    commit_cnt_s = '0;
    commit_s     = '0;
    flush_s      = 1'b0;
    redirect_s   = 32'h0;
    stop_s       = rst;
    for (int k = 0; k < COMMIT_W; k++) begin
      data_wb_bus[k] = '0;
    end
    for (int k = 0; k < ACTIVE_COMMIT; k++) begin
      commit_idx_s[k] = head_idx_s + ROB_ID_SIZE'(k);
      if (!stop_s && rob_q[commit_idx_s[k]].valid && rob_q[commit_idx_s[k]].done) begin
        commit_s[k]            = 1'b1;
        commit_cnt_s           = commit_cnt_s + ROB_PTR_W'(1);
        data_wb_bus[k].ready   = 1'b1;
        data_wb_bus[k].rd_addr = rob_q[commit_idx_s[k]].rd_addr;
        data_wb_bus[k].rd_data = rob_q[commit_idx_s[k]].data;
        data_wb_bus[k].rob_id  = commit_idx_s[k];
        if (rob_q[commit_idx_s[k]].mispredict) begin
          flush_s    = 1'b1;
          redirect_s = rob_q[commit_idx_s[k]].target;
          stop_s     = 1'b1;
        end
      end else begin
        stop_s = 1'b1;
      end
    end
  end

  // Entry next-state: a flush discards everything, else complete, retire, then allocate.
  always_comb begin
    rob_d = rob_q;
    if (flush_s) begin
      for (int j = 0; j < DEPTH; j++) begin
        rob_d[j].valid = 1'b0;
        rob_d[j].done  = 1'b0;
      end
    end else begin
      for (int c = 0; c < CDB_W; c++) begin
        if (cdb_bus[c].valid && rob_q[cdb_bus[c].rob_id].valid) begin
          rob_d[cdb_bus[c].rob_id].done       = 1'b1;
          rob_d[cdb_bus[c].rob_id].data       = cdb_bus[c].data;
          rob_d[cdb_bus[c].rob_id].mispredict = cdb_bus[c].mispredict;
          rob_d[cdb_bus[c].rob_id].target     = cdb_bus[c].target;
        end
      end
      for (int k = 0; k < ACTIVE_COMMIT; k++) begin
        if (commit_s[k]) begin
          rob_d[commit_idx_s[k]].valid = 1'b0;
          rob_d[commit_idx_s[k]].done  = 1'b0;
        end
      end
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (alloc_fire_s[i]) begin
          rob_d[alloc_idx_s[i]] = '{valid: 1'b1, done: 1'b0,
                                    rd_addr: decode_rob_bus[i].rd_addr,
                                    data: 32'h0, mispredict: 1'b0, target: 32'h0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        rob_q[j] <= '0;
      end
    end else begin
      rob_q <= rob_d;
    end
  end

  assign alloc_ok          = alloc_ok_s;
  assign rob_head_ptr      = tail_idx_s;
  assign rob_empty         = empty_s;
  assign branch_mispredict = flush_s;
  assign redirect_pc       = redirect_s;

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2**ROB_ID_SIZE, meaning entry count (power of two).
REQ-002 SHALL have parameter DISPATCH_W, default SS_DISPATCH_WIDTH (2), meaning allocation ports.
REQ-003 SHALL have parameter COMMIT_W, default COMMIT_FACTOR (2), meaning commit ports.
REQ-004 SHALL have parameter CDB_W, default 2, meaning completion ports.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port decode_rob_bus, input, decode_rob_bus_t[DISPATCH_W], allocation requests (.ready = valid, .rd_addr).
REQ-008 SHALL have port alloc_ok, output, 1, meaning at least DISPATCH_W entries are free.
REQ-009 SHALL have port rob_head_ptr, output, ROB_ID_SIZE, meaning ID given to port 0 this cycle (port i gets +i); consumed by the register file.
REQ-010 SHALL have port cdb_bus, input, cdb_bus_t[CDB_W], completions (.valid, .rob_id, .data, .mispredict, .target).
REQ-011 SHALL have port data_wb_bus, output, rob_reg_data_bus_t[COMMIT_W], commits (.ready, .rd_addr, .rd_data, .rob_id).
REQ-012 SHALL have port branch_mispredict, output, 1, flush pulse.
REQ-013 SHALL have port redirect_pc, output, 32, refetch target.
REQ-014 SHALL have port rob_empty, output, 1, no valid entries.

Function
REQ-015 SHALL keep head and tail pointers of ROB_ID_SIZE+1 bits; MSB is the wrap bit; full = equal index and differing MSB.
REQ-016 SHALL allocate entry tail+i for each port i with .ready set, marking valid=1 and done=0 and latching rd_addr, only when alloc_ok=1; requests with alloc_ok=0 are dropped.
REQ-017 SHALL require contiguous requests (port 1 implies port 0); tail advances by the request count.
REQ-018 SHALL, on cdb valid to a valid entry, latch data/mispredict/target and set done on the next edge; completion to an invalid entry is ignored.
REQ-019 SHALL NOT bypass CDB to commit: an entry completing in cycle N commits at the earliest in cycle N+1.
REQ-020 SHALL drive data_wb_bus[0].ready combinationally when the head entry is valid and done; that entry retires on the edge.
REQ-021 SHALL commit head+k on port k only if ports 0..k-1 commit and none of those entries has mispredict set.
REQ-022 SHALL, when a committing entry has mispredict set, assert branch_mispredict and redirect_pc=target in that same cycle, still writing its rd.
REQ-023 SHALL, on the edge after branch_mispredict, clear all valid bits, set head=tail=0, and ignore that cycle's allocations and completions.
REQ-024 SHALL handle simultaneous allocate, complete, and commit in one cycle; free count uses pre-edge occupancy (no same-cycle reuse of retiring slots).
REQ-025 SHALL commit rd_addr 0 entries normally (ready=1); the register file discards the write.
REQ-026 SHALL handle pointer wrap from DEPTH-1 to 0 transparently for IDs and commits.

Reset
REQ-027 SHALL, on rst, clear all valid/done bits, set head=tail=0, and drive rob_head_ptr=0, alloc_ok=1, rob_empty=1, branch_mispredict=0, redirect_pc=0, all data_wb_bus.ready=0.
REQ-028 SHALL give rst priority over flush, allocation, and completion in the same cycle.

Configuration
REQ-029 SHALL, with ROB_DUAL_COMMIT_EN defined, commit up to COMMIT_W entries per cycle (REQ-021); without it, only port 0 commits and ports 1..COMMIT_W-1 drive ready=0.

Structure
REQ-030 SHALL take ROB_ID_SIZE, rob_entry_t, cdb_bus_t, decode_rob_bus_t, and rob_reg_data_bus_t from package rv32i_types.
REQ-031 SHALL place pointer/occupancy arithmetic in a sub-module rob_ptr_ctrl; entry storage and commit select stay in reorder_buffer.

Verification
REQ-032 SHALL cover: rst; two allocations (rd 5, rd 6) -> rob_head_ptr 0 then 2; CDB id1 data 0x22 then id0 data 0x11 -> next cycle both commit together, in order (x5=0x11, x6=0x22).
REQ-033 SHALL cover: allocate until full (DEPTH entries) -> alloc_ok=0; further requests dropped; one commit pair frees slots -> alloc_ok=1 the next cycle.
REQ-034 SHALL cover: id3 completes with mispredict, target 0x8000_0040 -> on its commit branch_mispredict=1, redirect_pc=0x8000_0040, port 1 not committing; next cycle rob_empty=1, rob_head_ptr=0.
REQ-035 SHALL cover: completion to a freed ID (stale) -> no state change, no commit.
REQ-036 SHALL cover: tail at DEPTH-1 with two allocations -> IDs DEPTH-1 and 0; both commit in order after completion.
REQ-037 SHALL cover: ROB_DUAL_COMMIT_EN undefined, two done entries -> commits on consecutive cycles, port 1 ready always 0.
